// File: rtl/maze_rom_arbiter_pkg.sv
// Shared constants and types for the maze wall ROM arbiter.
// Requester indices follow the sprite order used by the movement FSMs.
package pac_maze_pkg;
  localparam int COORD_W   = 5;
  localparam int MAZE_ROWS = 24;
  localparam int MAZE_COLS = 32;
  localparam int NUM_REQ   = 5;

  localparam int REQ_PAC    = 0;
  localparam int REQ_BLINKY = 1;
  localparam int REQ_PINKY  = 2;
  localparam int REQ_INKY   = 3;
  localparam int REQ_CLYDE  = 4;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} arb_state_t;
endpackage

// File: rtl/maze_rom_arbiter_if.sv
// Requester/ROM bus for the maze arbiter; master = requesters plus ROM, slave = arbiter.
interface maze_rom_arbiter_if #(
  parameter int NUM_REQ = 5,
  parameter int COORD_W = 5
);
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*COORD_W-1:0] req_x;
  logic [NUM_REQ*COORD_W-1:0] req_y;
  logic [NUM_REQ-1:0]         resp_valid;
  logic                       resp_blocked;
  logic                       busy;
  logic [COORD_W-1:0]         rom_addr;
  logic [31:0]                rom_data;

  modport master (output req, req_x, req_y, rom_data,
                  input  resp_valid, resp_blocked, busy, rom_addr);
  modport slave  (input  req, req_x, req_y, rom_data,
                  output resp_valid, resp_blocked, busy, rom_addr);
endinterface

// File: rtl/maze_rom_arbiter_rr_pick.sv
// Round-robin picker: first set bit of req at or after ptr, wrapping.
// Purely combinational so it can be reused for other shared resources.
module rr_pick #(
  parameter int N     = 5,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);
  always_comb begin
    int j;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j -= N;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end
endmodule

// File: rtl/maze_rom_arbiter.sv
// Arbitrates the single-port maze wall ROM between Pac-Man and the ghosts.
// One 4-cycle transaction per grant: IDLE(grant) -> ADDR -> DATA(respond) -> DONE.
module maze_rom_arbiter #(
  parameter int NUM_REQ   = 5,
  parameter int COORD_W   = 5,
  parameter int MAZE_ROWS = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  maze_rom_arbiter_if.slave bus
);
  import pac_maze_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t         state;
  logic [IDX_W-1:0]   ptr, id_q, pick_idx;
  logic               pick_found;
  logic [COORD_W-1:0] x_q, y_q, sel_x, sel_y, col;

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req  (bus.req),
    .ptr  (ptr),
    .found(pick_found),
    .idx  (pick_idx)
  );

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_x = bus.req_x[i*COORD_W +: COORD_W];
        sel_y = bus.req_y[i*COORD_W +: COORD_W];
      end
    end
  end

  // Column 0 is the MSB of the row word.
  assign col = COORD_W'(MAZE_COLS - 1) - x_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      ptr              <= '0;
      id_q             <= '0;
      x_q              <= '0;
      y_q              <= '0;
      bus.rom_addr     <= '0;
      bus.resp_valid   <= '0;
      bus.resp_blocked <= 1'b0;
      bus.busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pick_found) begin
          id_q         <= pick_idx;
          x_q          <= sel_x;
          y_q          <= sel_y;
          bus.rom_addr <= sel_y;
          bus.busy     <= 1'b1;
          state        <= ADDR;
        end
        ADDR: state <= DATA;
        DATA: begin
          // Rows past the initialised maze read as solid wall.
          bus.resp_blocked <= (int'(y_q) >= MAZE_ROWS) ? 1'b1 : bus.rom_data[col];
          bus.resp_valid   <= NUM_REQ'(1) << id_q;
          state            <= DONE;
        end
        DONE: begin
          // req is ignored here so a requester still holding req is not re-granted early.
          bus.resp_valid <= '0;
          bus.busy       <= 1'b0;
          ptr            <= (id_q == IDX_W'(NUM_REQ - 1)) ? '0 : id_q + IDX_W'(1);
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_maze_rom_arbiter.sv
// Bench for maze_rom_arbiter: transaction-level reference model, vector table,
// hand-written corner sequences and randomized requester traffic.
module tb_maze_rom_arbiter;
  import pac_maze_pkg::*;

  localparam int NR = 5;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  maze_rom_arbiter_if #(.NUM_REQ(NR), .COORD_W(CW)) bus ();

  maze_rom_arbiter #(.NUM_REQ(NR), .COORD_W(CW), .MAZE_ROWS(24)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [31:0] rom [32];
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [NR-1:0] rq;
  logic [CW-1:0] xs [NR];
  logic [CW-1:0] ys [NR];

  // Reference model state: one transaction at a time, granted at edge m_g.
  int   m_ptr, m_free, m_g, m_id;
  bit   m_act;
  logic m_blk_g, m_blk;
  logic [CW-1:0] m_addr;

  int seen [$];
  int seen_cyc [$];

  typedef struct {
    int          id;
    logic [4:0]  x;
    logic [4:0]  y;
    logic        blk;
  } vec_t;
  vec_t tbl [7];

  function automatic logic ref_blocked(int x, int y);
    if (y >= 24) return 1'b1;
    return rom[y][31 - x];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive();
    bus.req = rq;
    for (int i = 0; i < NR; i++) begin
      bus.req_x[i*CW +: CW] = xs[i];
      bus.req_y[i*CW +: CW] = ys[i];
    end
  endtask

  // Advance one clock: update the model for the coming edge, then check at the negedge.
  task automatic step();
    logic [31:0] exp_v;
    logic        exp_busy;
    drive();
    cyc++;
    if (!rst_n) begin
      m_act = 0; m_ptr = 0; m_free = 0; m_blk = 1'b0; m_addr = '0;
    end else if (cyc >= m_free && rq != '0) begin
      int w;
      w = -1;
      for (int k = 0; k < NR; k++) begin
        int j;
        j = (m_ptr + k) % NR;
        if (w < 0 && rq[j]) w = j;
      end
      m_act   = 1;
      m_g     = cyc;
      m_id    = w;
      m_blk_g = ref_blocked(int'(xs[w]), int'(ys[w]));
      m_free  = cyc + 4;
      m_ptr   = (w + 1) % NR;
      m_addr  = ys[w];
    end
    @(posedge clk);
    @(negedge clk);
    exp_v = '0;
    if (m_act && cyc == m_g + 2) begin
      exp_v = 32'd1 << m_id;
      m_blk = m_blk_g;
    end
    exp_busy = m_act && cyc >= m_g && cyc <= m_g + 2;
    chk("resp_valid", 32'(bus.resp_valid), exp_v);
    chk("busy", 32'(bus.busy), 32'(exp_busy));
    chk("rom_addr", 32'(bus.rom_addr), 32'(m_addr));
    chk("resp_blocked", 32'(bus.resp_blocked), 32'(m_blk));
    chk("onehot", 32'($onehot0(bus.resp_valid)), 32'd1);
    for (int i = 0; i < NR; i++)
      if (bus.resp_valid[i] === 1'b1) begin
        seen.push_back(i);
        seen_cyc.push_back(cyc);
      end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rq = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int r = 0; r < 32; r++) rom[r] = (r < 24) ? ($urandom | 32'h8000_0001) : 32'h0;
    rom[4]  = 32'h8001_0001;
    rom[12] = 32'h8001_0001;
    for (int i = 0; i < NR; i++) begin xs[i] = '0; ys[i] = '0; end
    rq = '0;
    m_act = 0; m_ptr = 0; m_free = 0; m_blk = 1'b0; m_addr = '0;

    tbl[0] = '{REQ_PAC,    5'd6,  5'd4,  1'b0};
    tbl[1] = '{REQ_PAC,    5'd15, 5'd4,  1'b1};
    tbl[2] = '{REQ_PAC,    5'd0,  5'd4,  1'b1};
    tbl[3] = '{REQ_PAC,    5'd5,  5'd12, 1'b0};
    tbl[4] = '{REQ_PINKY,  5'd10, 5'd26, 1'b1};
    tbl[5] = '{REQ_CLYDE,  5'd31, 5'd4,  1'b1};
    tbl[6] = '{REQ_INKY,   5'd16, 5'd4,  1'b0};

    do_reset();

    foreach (tbl[v]) begin
      rq = NR'(1) << tbl[v].id;
      xs[tbl[v].id] = tbl[v].x;
      ys[tbl[v].id] = tbl[v].y;
      step(); step(); step();
      chk("tbl_valid", 32'(bus.resp_valid), 32'd1 << tbl[v].id);
      chk("tbl_blocked", 32'(bus.resp_blocked), 32'(tbl[v].blk));
      rq = '0;
      step();
      chk("tbl_idle", 32'(bus.busy), 32'd0);
    end

    // All five requesting continuously from reset.
    do_reset();
    for (int i = 0; i < NR; i++) begin xs[i] = 5'($urandom); ys[i] = 5'($urandom); end
    rq = '1;
    seen.delete(); seen_cyc.delete();
    repeat (24) step();
    chk("all_count", 32'(seen.size()), 32'd6);
    for (int k = 0; k < 6 && k < seen.size(); k++) chk("all_order", 32'(seen[k]), 32'(k % NR));
    for (int k = 1; k < seen_cyc.size(); k++) chk("all_spacing", 32'(seen_cyc[k] - seen_cyc[k-1]), 32'd4);
    rq = '0;
    repeat (4) step();

    // Requester 1 held through DONE while 3 is pending.
    do_reset();
    rq = 5'b01010;
    seen.delete(); seen_cyc.delete();
    repeat (12) step();
    chk("hold_count", 32'(seen.size()), 32'd3);
    if (seen.size() >= 3) begin
      chk("hold_first", 32'(seen[0]), 32'd1);
      chk("no_regrant", 32'(seen[1]), 32'd3);
      chk("hold_third", 32'(seen[2]), 32'd1);
    end
    rq = '0;
    repeat (4) step();

    // Requester 1 alone: re-granted only after returning to IDLE.
    do_reset();
    rq = 5'b00010;
    seen.delete(); seen_cyc.delete();
    repeat (8) step();
    chk("solo_count", 32'(seen_cyc.size()), 32'd2);
    if (seen_cyc.size() >= 2) chk("solo_gap", 32'(seen_cyc[1] - seen_cyc[0]), 32'd4);
    rq = '0;
    repeat (4) step();

    // Reset during DATA, then ptr must be back at 0.
    do_reset();
    rq = 5'b01000; xs[3] = 5'd1; ys[3] = 5'd4;
    step(); step(); step();
    rq = '0;
    step();
    rq = 5'b00100; xs[2] = 5'd2; ys[2] = 5'd5;
    step(); step();
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.resp_valid), 32'd0);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    chk("async_rst_addr", 32'(bus.rom_addr), 32'd0);
    rq = '0;
    step(); step();
    rst_n = 1'b1;
    rq = 5'b11000; xs[4] = 5'd7; ys[4] = 5'd3;
    seen.delete(); seen_cyc.delete();
    repeat (4) step();
    chk("rst_ptr_count", 32'(seen.size()), 32'd1);
    if (seen.size() >= 1) chk("rst_ptr_winner", 32'(seen[0]), 32'd3);
    rq = '0;
    repeat (4) step();

    // Randomized requester traffic obeying the handshake.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (rq[i]) begin
          if (bus.resp_valid[i] === 1'b1) begin
            if ($urandom_range(0, 1) == 0) rq[i] = 1'b0;
            else begin xs[i] = 5'($urandom); ys[i] = 5'($urandom); end
          end else if ($urandom_range(0, 99) < 2) begin
            rq[i] = 1'b0;
          end
        end else if ($urandom_range(0, 99) < 30) begin
          rq[i] = 1'b1;
          xs[i] = 5'($urandom_range(0, 31));
          ys[i] = 5'($urandom_range(0, 31));
        end
      end
      step();
    end
    rq = '0;
    repeat (6) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/maze_rom_arbiter.md
Name: maze_rom_arbiter

Overview:
Shares the single-read-port maze wall ROM (32 rows x 32 bits, 1-cycle registered read) between Pac-Man and the ghost movement controllers. Each requester asks "is tile (x,y) blocked?". The block arbitrates round-robin, sequences the ROM address/data timing, extracts the tile bit, and returns a one-cycle response to the granted requester. It sits between the sprite movement FSMs and the maze ROM instance.

Parameters:
NUM_REQ, 5, number of requesters; index 0 = Pac-Man, 1..4 = ghosts.
COORD_W, 5, width of the x and y tile coordinates.
MAZE_ROWS, 24, number of initialised ROM rows; y >= MAZE_ROWS is treated as a wall.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req  in  NUM_REQ  per-requester request level.
req_x  in  NUM_REQ*COORD_W  flattened tile column per requester; requester i uses slice [i*COORD_W +: COORD_W].
req_y  in  NUM_REQ*COORD_W  flattened tile row per requester, same slicing.
resp_valid  out  NUM_REQ  one-cycle pulse to the serviced requester.
resp_blocked  out  1  1 = tile is a wall; valid only while any resp_valid bit is high.
busy  out  1  high while a transaction is in progress (state != IDLE).
rom_addr  out  COORD_W  row address to the ROM (registered).
rom_data  in  32  ROM row data, valid one cycle after rom_addr is sampled.

Behaviour:
- Reset (async, rst_n low): state=IDLE; rom_addr=0; resp_valid=0; resp_blocked=0; busy=0; rr pointer=0; latched id/x/y=0. Reset mid-transaction aborts it with no response.
- Handshake: requester raises req[i] and holds x/y stable until it sees resp_valid[i]. It then drops or re-arms req[i] from the next edge. Coordinates are latched at grant, so later changes do not affect the transaction in flight.
- Bit mapping: column x selects rom_data[31 - x]. Column 0 is the MSB, the leftmost character of the row literal.
- FSM, 4 states, one transaction per 4 cycles:
  - IDLE: if any req bit is high, grant the first set bit searching from ptr upward with wrap. Latch id, x and y; rom_addr <= y; busy <= 1; go to ADDR. With no request, stay in IDLE.
  - ADDR: the ROM samples rom_addr on this edge; go to DATA.
  - DATA: rom_data is valid. resp_blocked <= (y >= MAZE_ROWS) ? 1 : rom_data[31 - x]; resp_valid[id] <= 1; go to DONE.
  - DONE: resp_valid <= 0; ptr <= (id == NUM_REQ-1) ? 0 : id+1; go to IDLE. req is ignored in this state, so a requester still holding req at this edge is not re-granted spuriously.
- Latency: req[i] sampled in IDLE at edge E0 -> resp_valid[i] high for exactly the cycle between E2 and E3. busy is high from E0 to E3.
- Fairness: a requester holding req continuously is serviced within NUM_REQ transactions (at most 4*NUM_REQ cycles).
- Simultaneous requests: the lowest index at or after ptr wins. After reset, Pac-Man (0) wins ties.
- Requester drops req mid-transaction: the transaction completes and the response pulse is still issued.
- Only one resp_valid bit is ever high at a time. resp_blocked holds its last value outside response cycles.
- Out-of-range y (24..31): full sequence and latency are kept; the response is forced to blocked=1.

Decomposition:
- Package pac_maze_pkg holds:
  - COORD_W, MAZE_ROWS, MAZE_COLS=32.
  - Requester index constants: REQ_PAC=0, REQ_BLINKY=1, REQ_PINKY=2, REQ_INKY=3, REQ_CLYDE=4.
  - Enum arb_state_t {IDLE, ADDR, DATA, DONE}.
- One combinational sub-module, rr_pick (inputs req vector and ptr; outputs found and idx), is natural and reusable for other shared resources.

Test Plan:
- Reset, then req[0]=1 with x=6, y=4 -> rom_addr=4 after E0; resp_valid=5'b00001 in the cycle after E2; resp_blocked=0 (row 4, column 6 free); busy low after E3.
- req[0] with x=15, y=4, then x=0, y=4 -> resp_blocked=1 both times (row 4 columns 15 and 0 are walls); x=5, y=12 -> resp_blocked=0.
- All five req high continuously from reset -> grant order 0,1,2,3,4,0, one response every 4 cycles, no two resp_valid bits high together.
- req[2] with y=26, x=10 -> resp_blocked=1, response still at E2 latency.
- req[1] still held through DONE -> no extra grant at the DONE edge; next grant goes to another pending requester, or to 1 only after IDLE.
- rst_n pulsed low during DATA -> resp_valid stays 0, busy=0 and rom_addr=0 immediately; after release, a new req[3] is serviced normally with ptr=0 priority.
